// File: rtl/traffic_monitor.sv
// Watches the lamp drives of a traffic controller and flags the first
// sequencing, dwell or walk violation, counting legal RED->GREEN->YELLOW cycles.
module traffic_monitor #(
    parameter int MIN_RED    = 16,
    parameter int MAX_RED    = 256,
    parameter int MIN_GREEN  = 16,
    parameter int MAX_GREEN  = 256,
    parameter int MIN_YELLOW = 4,
    parameter int MAX_YELLOW = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        led2,
    input  logic        led3,
    input  logic        led4,
    input  logic        led5,
    output logic [1:0]  phase,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [15:0] cycle_count,
    output logic        phase_done
);

    localparam logic [2:0] S_UNSYNC = 3'd0;
    localparam logic [2:0] S_RED    = 3'd1;
    localparam logic [2:0] S_GREEN  = 3'd2;
    localparam logic [2:0] S_YELLOW = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    logic        red_q, red_d, yel_q, yel_d, grn_q, grn_d, walk_q, walk_d;
    logic [2:0]  state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [8:0]  dwell_q, dwell_d;
    logic        first_q, first_d;
    logic        fault_q, fault_d;
    logic [2:0]  code_q, code_d;
    logic [15:0] count_q, count_d;
    logic        done_q, done_d;

    logic        lamp_ok;
    logic [1:0]  lamp, cur, nxt;
    logic [9:0]  min_lim, max_lim;
    logic        v_enc, v_walk, v_order, v_short, v_long;
    logic [2:0]  viol;

    always_comb begin
        red_d   = led2;
        yel_d   = led3;
        grn_d   = led4;
        walk_d  = led5;
        state_d = state_q;
        phase_d = phase_q;
        dwell_d = dwell_q;
        first_d = first_q;
        fault_d = fault_q;
        code_d  = code_q;
        count_d = count_q;
        done_d  = 1'b0;

        lamp_ok = (red_q ^ yel_q ^ grn_q) && !(red_q && yel_q && grn_q);
        lamp    = red_q ? 2'd1 : (grn_q ? 2'd2 : 2'd3);
        cur     = state_q[1:0];
        nxt     = (cur == 2'd3) ? 2'd1 : cur + 2'd1;

        min_lim = 10'(MIN_RED);
        max_lim = 10'(MAX_RED);
        case (state_q)
            S_GREEN: begin
                min_lim = 10'(MIN_GREEN);
                max_lim = 10'(MAX_GREEN);
            end
            S_YELLOW: begin
                min_lim = 10'(MIN_YELLOW);
                max_lim = 10'(MAX_YELLOW);
            end
            default: ;
        endcase

        // The RED entered on synchronisation may be a partial dwell.
        v_enc   = !lamp_ok;
        v_walk  = walk_q && (state_q != S_RED);
        v_order = lamp_ok && (lamp != cur) && (lamp != nxt);
        v_short = lamp_ok && (lamp == nxt)
                  && ({1'b0, dwell_q} < min_lim)
                  && !((state_q == S_RED) && first_q);
        v_long  = lamp_ok && (lamp == cur) && ({1'b0, dwell_q} == max_lim);

        if (v_enc)        viol = 3'd1;
        else if (v_walk)  viol = 3'd5;
        else if (v_order) viol = 3'd2;
        else if (v_short) viol = 3'd3;
        else if (v_long)  viol = 3'd4;
        else              viol = 3'd0;

        case (state_q)
            S_UNSYNC: begin
                if (lamp_ok && red_q) begin
                    state_d = S_RED;
                    phase_d = 2'd1;
                    dwell_d = 9'd1;
                    first_d = 1'b1;
                end
            end
            S_RED, S_GREEN, S_YELLOW: begin
                if (viol != 3'd0) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    code_d  = viol;
                end else if (lamp == nxt) begin
                    state_d = {1'b0, nxt};
                    phase_d = nxt;
                    dwell_d = 9'd1;
                    first_d = 1'b0;
                    done_d  = 1'b1;
                    if (state_q == S_YELLOW && count_q != 16'hFFFF)
                        count_d = count_q + 16'd1;
                end else begin
                    dwell_d = dwell_q + 9'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            red_q   <= 1'b0;
            yel_q   <= 1'b0;
            grn_q   <= 1'b0;
            walk_q  <= 1'b0;
            state_q <= S_UNSYNC;
            phase_q <= 2'd0;
            dwell_q <= 9'd0;
            first_q <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= 3'd0;
            count_q <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            red_q   <= red_d;
            yel_q   <= yel_d;
            grn_q   <= grn_d;
            walk_q  <= walk_d;
            state_q <= state_d;
            phase_q <= phase_d;
            dwell_q <= dwell_d;
            first_q <= first_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign phase       = phase_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign cycle_count = count_q;
    assign phase_done  = done_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: expected outputs are queued as each
// stimulus step is driven and compared once the DUT has had time to respond.
module tb_traffic_monitor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        led2 = 1'b0, led3 = 1'b0, led4 = 1'b0, led5 = 1'b0;
    logic [1:0]  phase;
    logic        fault;
    logic [2:0]  fault_code;
    logic [15:0] cycle_count;
    logic        phase_done;

    always #5 clock = ~clock;

    traffic_monitor dut (
        .clock      (clock),
        .reset      (reset),
        .led2       (led2),
        .led3       (led3),
        .led4       (led4),
        .led5       (led5),
        .phase      (phase),
        .fault      (fault),
        .fault_code (fault_code),
        .cycle_count(cycle_count),
        .phase_done (phase_done)
    );

    typedef struct {
        string       tag;
        logic [1:0]  ph;
        logic        f;
        logic [2:0]  code;
        logic [15:0] cnt;
        logic        pd;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   pd_cnt   = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (phase_done === 1'b1) pd_cnt++;
        end
    endtask

    task automatic lamps(input logic r, input logic y, input logic g,
                         input logic w);
        led2 = r;
        led3 = y;
        led4 = g;
        led5 = w;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] ph,
                              input logic f, input logic [2:0] code,
                              input logic [15:0] cnt, input logic pd);
        exp_t e;
        e.tag  = tag;
        e.ph   = ph;
        e.f    = f;
        e.code = code;
        e.cnt  = cnt;
        e.pd   = pd;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            n_assert++;
            assert (phase === e.ph) else begin
                n_fail++;
                $error("FAIL %s phase: observed %0d expected %0d",
                       e.tag, phase, e.ph);
            end
            n_assert++;
            assert (fault === e.f) else begin
                n_fail++;
                $error("FAIL %s fault: observed %0b expected %0b",
                       e.tag, fault, e.f);
            end
            n_assert++;
            assert (fault_code === e.code) else begin
                n_fail++;
                $error("FAIL %s fault_code: observed %0d expected %0d",
                       e.tag, fault_code, e.code);
            end
            n_assert++;
            assert (cycle_count === e.cnt) else begin
                n_fail++;
                $error("FAIL %s cycle_count: observed %0d expected %0d",
                       e.tag, cycle_count, e.cnt);
            end
            n_assert++;
            assert (phase_done === e.pd) else begin
                n_fail++;
                $error("FAIL %s phase_done: observed %0b expected %0b",
                       e.tag, phase_done, e.pd);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        lamps(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        expect_out(tag, 2'd0, 1'b0, 3'd0, 16'd0, 1'b0);
        tick(1);
        check_out();
        reset = 1'b0;
    endtask

    // Syncs on RED then holds GREEN for n cycles; leaves GREEN on the lamps.
    task automatic red_then_green(input int n);
        lamps(1'b1, 1'b0, 1'b0, 1'b0);
        tick(20);
        lamps(1'b0, 1'b0, 1'b1, 1'b0);
        tick(n);
    endtask

    initial begin
        // Reset state
        tick(1);
        do_reset("reset_init");

        // Legal run: three full cycles, walk only inside RED
        pd_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            lamps(1'b1, 1'b0, 1'b0, 1'b0);
            tick(1);
            lamps(1'b1, 1'b0, 1'b0, 1'b1);
            tick(18);
            lamps(1'b1, 1'b0, 1'b0, 1'b0);
            tick(1);
            lamps(1'b0, 1'b0, 1'b1, 1'b0);
            expect_out("g_latency", 2'd1, 1'b0, 3'd0, 16'(k), 1'b0);
            tick(1);
            check_out();
            expect_out("g_entry", 2'd2, 1'b0, 3'd0, 16'(k), 1'b1);
            tick(1);
            check_out();
            tick(18);
            lamps(1'b0, 1'b1, 1'b0, 1'b0);
            expect_out("y_latency", 2'd2, 1'b0, 3'd0, 16'(k), 1'b0);
            tick(1);
            check_out();
            expect_out("y_entry", 2'd3, 1'b0, 3'd0, 16'(k), 1'b1);
            tick(1);
            check_out();
            tick(4);
        end
        lamps(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        expect_out("r_entry", 2'd1, 1'b0, 3'd0, 16'd3, 1'b1);
        tick(1);
        check_out();
        expect_out("run_end", 2'd1, 1'b0, 3'd0, 16'd3, 1'b0);
        tick(5);
        check_out();
        n_assert++;
        assert (pd_cnt === 9) else begin
            n_fail++;
            $error("FAIL pulse_count: observed %0d expected 9", pd_cnt);
        end

        // Short GREEN
        do_reset("reset_b");
        red_then_green(10);
        lamps(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("short_pre", 2'd2, 1'b0, 3'd0, 16'd0, 1'b0);
        tick(1);
        check_out();
        expect_out("short_green", 2'd2, 1'b1, 3'd3, 16'd0, 1'b0);
        tick(1);
        check_out();
        lamps(1'b0, 1'b0, 1'b1, 1'b1);
        expect_out("fault_hold", 2'd2, 1'b1, 3'd3, 16'd0, 1'b0);
        tick(10);
        check_out();

        // Stuck YELLOW
        do_reset("reset_c");
        red_then_green(20);
        lamps(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("yellow_dwell64", 2'd3, 1'b0, 3'd0, 16'd0, 1'b0);
        tick(65);
        check_out();
        expect_out("yellow_long", 2'd3, 1'b1, 3'd4, 16'd0, 1'b0);
        tick(1);
        check_out();

        // Order violation GREEN -> RED
        do_reset("reset_d");
        red_then_green(20);
        lamps(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("order", 2'd2, 1'b1, 3'd2, 16'd0, 1'b0);
        tick(2);
        check_out();

        // Encoding beats walk and order in the same cycle
        do_reset("reset_d2");
        red_then_green(20);
        lamps(1'b1, 1'b0, 1'b1, 1'b1);
        expect_out("enc_priority", 2'd2, 1'b1, 3'd1, 16'd0, 1'b0);
        tick(2);
        check_out();

        // Walk during GREEN, then a one-cycle reset out of FAULT
        do_reset("reset_e");
        red_then_green(10);
        lamps(1'b0, 1'b0, 1'b1, 1'b1);
        expect_out("walk_green", 2'd2, 1'b1, 3'd5, 16'd0, 1'b0);
        tick(2);
        check_out();
        reset = 1'b1;
        expect_out("reset_fault", 2'd0, 1'b0, 3'd0, 16'd0, 1'b0);
        tick(1);
        check_out();
        reset = 1'b0;
        expect_out("unsync_ignore", 2'd0, 1'b0, 3'd0, 16'd0, 1'b0);
        tick(3);
        check_out();

        // UNSYNC start on GREEN with walk, short first RED is exempt
        do_reset("reset_f");
        lamps(1'b0, 1'b0, 1'b1, 1'b1);
        expect_out("unsync_green", 2'd0, 1'b0, 3'd0, 16'd0, 1'b0);
        tick(30);
        check_out();
        lamps(1'b1, 1'b0, 1'b0, 1'b0);
        tick(3);
        lamps(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("sync_short_red", 2'd2, 1'b0, 3'd0, 16'd0, 1'b1);
        tick(2);
        check_out();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
